fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling instruction queue between the fetch stage and decode. Accepts 2-wide fetch bundles (instruction, PC, valid mask, branch-prediction metadata), compacts them into a circular buffer, and presents up to two in-order entries per cycle to decode. Generates the fetch-side stall with enough slack to absorb the bundle already in flight out of fetch's output registers.

## Interface
- DEPTH, 8: entries; power of two, ≥ 4.
- INST_WIDTH, 32: instruction word width.
- ADDR_WIDTH, 32: PC width.
- GHR_BITS, 8: branch-history snapshot width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush or redirect; empties queue.
- in_inst_valid  in  2  per-slot valid mask of the fetch bundle; bit 0 is slot 0.
- in_inst_addr_0 / in_inst_addr_1  in  ADDR_WIDTH  slot PCs.
- in_inst_0 / in_inst_1  in  INST_WIDTH  slot instructions.
- in_pred_taken_0 / in_pred_taken_1  in  1  predicted taken.
- in_pred_target_0 / in_pred_target_1  in  ADDR_WIDTH  predicted next PC.
- in_pred_hist_0 / in_pred_hist_1  in  GHR_BITS  history at prediction.
- fetch_stall  out  1  stall request to fetch.
- dec_ready  in  1  decode consumes all presented entries this cycle.
- out_valid  out  2  presented-entry mask: 2'b00, 2'b01 or 2'b11 only.
- out_inst_addr_0/1, out_inst_0/1, out_pred_taken_0/1, out_pred_target_0/1, out_pred_hist_0/1  out  as inputs  head entry (slot 0) and head+1 (slot 1).

## Operation
- State: storage[DEPTH] of {addr, inst, pred_taken, pred_target, pred_hist}; head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH); count (log2 DEPTH + 1 bits, 0..DEPTH).
- Enqueue, unconditional when flush=0 (fetch_stall never blocks the bundle currently presented):
  - 2'b00: nothing written.
  - 2'b01: slot 0 to storage[tail]; tail+1.
  - 2'b10: slot 1 to storage[tail]; tail+1.
  - 2'b11: slot 0 to storage[tail], slot 1 to storage[tail+1]; tail+2.
  - n_enq = popcount(in_inst_valid).
- Presentation (combinational from registered state): out_valid[0] = count ≥ 1; out_valid[1] = count ≥ 2. Slot 0 fields = storage[head], slot 1 fields = storage[head+1] (wrapped). Fields of invalid slots are don't-care.
- Dequeue: n_deq = dec_ready ? popcount(out_valid) : 0; head advances by n_deq.
- count_next = count + n_enq − n_deq (same-cycle enqueue and dequeue both apply).
- fetch_stall = (DEPTH − count) < 4, combinational from count only (dequeue credit is not used). Rationale: one bundle can be presented while stall is being raised, and one more is already in flight; 4 free entries cover both. Overflow is therefore impossible. The simulation assertion (n_enq > DEPTH − count + n_deq) flags any violation.
- flush=1: head, tail and count are cleared to 0; the incoming bundle and any dequeue that cycle are discarded. flush overrides everything.
- No bypass: an entry written at edge N is presented first in cycle N+1.

## Timing
- Reset (asynchronous, rst_n low): head=tail=count=0. Therefore out_valid=2'b00 and fetch_stall=0. Storage is not reset, so data outputs are don't-care while invalid.
- Enqueue-to-present latency: 1 cycle.
- Dequeue takes effect at the edge where dec_ready=1. The next entries are presented in the following cycle.
- Wrap-around: a two-entry write or read at index DEPTH−1 uses DEPTH−1 and 0.
- Full (count=DEPTH): out_valid=2'b11 and fetch_stall=1. Empty: out_valid=2'b00, and dec_ready is ignored.
- rst_n asserted mid-operation: all contents are dropped immediately, with no drain.

## Test plan
- Reset, then in_inst_valid=2'b11 with PCs 0x100/0x104 and dec_ready=0 → the next cycle shows out_valid=2'b11, out_inst_addr_0=0x100, out_inst_addr_1=0x104, count=2.
- Send bundle 2'b01 (PC 0x200, pred_taken=1, target 0x400), then bundle 2'b11 (0x400/0x404), with dec_ready=1 throughout → decode sees 0x200 alone, then 0x400/0x404 in order. pred_taken_0=1 and pred_target_0=0x400 are carried with 0x200.
- With dec_ready=0, send 2'b11 bundles continuously while honouring fetch_stall (fetch stops issuing the cycle after stall) → fetch_stall rises once count ≥ 5. count never exceeds 8 and the assertion never fires. Then dec_ready=1 drains 8 entries in PC order across the wrap boundary.
- count=1 with head at index 7; enqueue 2'b11 and dequeue in the same cycle → count=2, head=0, tail=2. Slot order is preserved across the wrap.
- count=6, flush=1 together with in_inst_valid=2'b11 and dec_ready=1 → the next cycle shows out_valid=2'b00, count=0, fetch_stall=0. The flushed bundle never appears.
- Bundle 2'b10 with slot-1 PC 0x504 into an empty queue → out_valid=2'b01 and out_inst_addr_0=0x504.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupling instruction queue between fetch and decode: compacts 2-wide fetch
// bundles into a circular buffer and presents up to two in-order entries per cycle.
module fetch_queue #(
  parameter int DEPTH      = 8,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            in_inst_valid,
  input  logic [ADDR_WIDTH-1:0] in_inst_addr_0,
  input  logic [ADDR_WIDTH-1:0] in_inst_addr_1,
  input  logic [INST_WIDTH-1:0] in_inst_0,
  input  logic [INST_WIDTH-1:0] in_inst_1,
  input  logic                  in_pred_taken_0,
  input  logic                  in_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0] in_pred_target_0,
  input  logic [ADDR_WIDTH-1:0] in_pred_target_1,
  input  logic [GHR_BITS-1:0]   in_pred_hist_0,
  input  logic [GHR_BITS-1:0]   in_pred_hist_1,
  output logic                  fetch_stall,
  input  logic                  dec_ready,
  output logic [1:0]            out_valid,
  output logic [ADDR_WIDTH-1:0] out_inst_addr_0,
  output logic [ADDR_WIDTH-1:0] out_inst_addr_1,
  output logic [INST_WIDTH-1:0] out_inst_0,
  output logic [INST_WIDTH-1:0] out_inst_1,
  output logic                  out_pred_taken_0,
  output logic                  out_pred_taken_1,
  output logic [ADDR_WIDTH-1:0] out_pred_target_0,
  output logic [ADDR_WIDTH-1:0] out_pred_target_1,
  output logic [GHR_BITS-1:0]   out_pred_hist_0,
  output logic [GHR_BITS-1:0]   out_pred_hist_1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * ADDR_WIDTH + INST_WIDTH + 1 + GHR_BITS;

  logic [ENT_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head_nx;
  logic [PTR_W-1:0] tail_nx;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  logic [CNT_W-1:0] free;
  logic [ENT_W-1:0] ent_0;
  logic [ENT_W-1:0] ent_1;
  logic [ENT_W-1:0] wr_0;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  assign ent_0 = {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
  assign ent_1 = {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};
  // A lone slot-1 instruction is compacted into the tail position.
  assign wr_0    = in_inst_valid[0] ? ent_0 : ent_1;
  assign head_nx = head + PTR_W'(1);
  assign tail_nx = tail + PTR_W'(1);

  assign n_enq     = popcnt2(in_inst_valid);
  assign out_valid = {count >= CNT_W'(2), count >= CNT_W'(1)};
  assign n_deq     = dec_ready ? popcnt2(out_valid) : 2'd0;

  // Stall from count alone leaves room for the bundle presented now plus one in flight.
  assign free        = CNT_W'(DEPTH) - count;
  assign fetch_stall = free < CNT_W'(4);

  assign {out_inst_addr_0, out_inst_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0} =
    storage[head];
  assign {out_inst_addr_1, out_inst_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1} =
    storage[head_nx];

  always_ff @(posedge clk) begin
    if (!flush && in_inst_valid != 2'b00) begin
      storage[tail] <= wr_0;
      if (in_inst_valid == 2'b11) begin
        storage[tail_nx] <= ent_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || flush)
    int'(n_enq) <= DEPTH - int'(count) + int'(n_deq));

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue tracks enqueued entries and
// is compared against the presented slots every cycle.
module tb_fetch_queue;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  hist;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  in_inst_valid = 2'b00;
  logic [31:0] in_inst_addr_0 = '0, in_inst_addr_1 = '0;
  logic [31:0] in_inst_0 = '0, in_inst_1 = '0;
  logic        in_pred_taken_0 = 1'b0, in_pred_taken_1 = 1'b0;
  logic [31:0] in_pred_target_0 = '0, in_pred_target_1 = '0;
  logic [7:0]  in_pred_hist_0 = '0, in_pred_hist_1 = '0;
  logic        fetch_stall;
  logic        dec_ready = 1'b0;
  logic [1:0]  out_valid;
  logic [31:0] out_inst_addr_0, out_inst_addr_1;
  logic [31:0] out_inst_0, out_inst_1;
  logic        out_pred_taken_0, out_pred_taken_1;
  logic [31:0] out_pred_target_0, out_pred_target_1;
  logic [7:0]  out_pred_hist_0, out_pred_hist_1;

  fetch_queue #(.DEPTH(8), .INST_WIDTH(32), .ADDR_WIDTH(32), .GHR_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_inst_valid(in_inst_valid),
    .in_inst_addr_0(in_inst_addr_0), .in_inst_addr_1(in_inst_addr_1),
    .in_inst_0(in_inst_0), .in_inst_1(in_inst_1),
    .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
    .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
    .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
    .fetch_stall(fetch_stall), .dec_ready(dec_ready), .out_valid(out_valid),
    .out_inst_addr_0(out_inst_addr_0), .out_inst_addr_1(out_inst_addr_1),
    .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    ent_t e;
    e.addr   = pc;
    e.inst   = pc ^ 32'hA5A5_5A5A;
    e.taken  = tk;
    e.target = tgt;
    e.hist   = pc[9:2];
    return e;
  endfunction

  task automatic bundle(input logic [1:0] v, input ent_t e0, input ent_t e1);
    in_inst_valid = v;
    {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0} = e0;
    {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1} = e1;
  endtask

  task automatic idle();
    in_inst_valid = 2'b00;
  endtask

  // One clock cycle: check presentation against the model, update the model, clock.
  task automatic step(input logic dr, input logic fl);
    ent_t s0, s1, e0, e1;
    int sz, nd;
    dec_ready = dr;
    flush     = fl;
    #1;
    sz = q.size();
    chk("count", 128'(dut.count), 128'(sz));
    chk("out_valid", 128'(out_valid), (sz >= 2) ? 128'd3 : (sz >= 1) ? 128'd1 : 128'd0);
    chk("fetch_stall", 128'(fetch_stall), 128'((8 - sz) < 4));
    s0 = {out_inst_addr_0, out_inst_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0};
    s1 = {out_inst_addr_1, out_inst_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1};
    if (sz >= 1) chk("slot0", 128'(s0), 128'(q[0]));
    if (sz >= 2) chk("slot1", 128'(s1), 128'(q[1]));
    nd = dr ? ((sz >= 2) ? 2 : sz) : 0;
    e0 = {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
    e1 = {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};
    if (fl) begin
      q.delete();
    end else begin
      repeat (nd) void'(q.pop_front());
      if (in_inst_valid[0]) q.push_back(e0);
      if (in_inst_valid[1]) q.push_back(e1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic st_prev, st_now;
    ent_t z;
    z = mk(32'h0, 1'b0, 32'h0);

    // Reset state
    #12;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_stall", 128'(fetch_stall), 128'd0);
    chk("rst_count", 128'(dut.count), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-wide enqueue, 1-cycle latency
    bundle(2'b11, mk(32'h100, 1'b0, 32'h108), mk(32'h104, 1'b0, 32'h108));
    step(1'b0, 1'b0);
    idle();
    chk("t1_count", 128'(dut.count), 128'd2);
    chk("t1_valid", 128'(out_valid), 128'd3);
    chk("t1_addr0", 128'(out_inst_addr_0), 128'h100);
    chk("t1_addr1", 128'(out_inst_addr_1), 128'h104);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Streaming with prediction metadata
    bundle(2'b01, mk(32'h200, 1'b1, 32'h400), z);
    step(1'b1, 1'b0);
    chk("t2_valid", 128'(out_valid), 128'd1);
    chk("t2_taken", 128'(out_pred_taken_0), 128'd1);
    chk("t2_target", 128'(out_pred_target_0), 128'h400);
    bundle(2'b11, mk(32'h400, 1'b0, 32'h408), mk(32'h404, 1'b0, 32'h408));
    step(1'b1, 1'b0);
    idle();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Fill while honouring stall, then drain across the wrap
    st_prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!st_prev)
        bundle(2'b11, mk(32'h1000 + 32'(8 * k), 1'b0, 32'h0), mk(32'h1004 + 32'(8 * k), 1'b0, 32'h0));
      else
        idle();
      st_now = (8 - q.size()) < 4;
      step(1'b0, 1'b0);
      st_prev = st_now;
    end
    idle();
    chk("t3_full_count", 128'(dut.count), 128'd8);
    chk("t3_full_stall", 128'(fetch_stall), 128'd1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);

    // count=1 with head at 7, enqueue two and dequeue one in the same cycle
    bundle(2'b01, mk(32'h3000, 1'b0, 32'h0), z);
    step(1'b0, 1'b0);
    bundle(2'b01, mk(32'h3004, 1'b0, 32'h0), z);
    step(1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0);
    bundle(2'b01, mk(32'h3008, 1'b0, 32'h0), z);
    step(1'b0, 1'b0);
    chk("t4_head_pre", 128'(dut.head), 128'd7);
    bundle(2'b11, mk(32'h300C, 1'b1, 32'h3100), mk(32'h3010, 1'b0, 32'h0));
    step(1'b1, 1'b0);
    idle();
    chk("t4_count", 128'(dut.count), 128'd2);
    chk("t4_head", 128'(dut.head), 128'd0);
    chk("t4_tail", 128'(dut.tail), 128'd2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Flush with a bundle and dequeue in the same cycle
    for (int k = 0; k < 3; k++) begin
      bundle(2'b11, mk(32'h6000 + 32'(8 * k), 1'b0, 32'h0), mk(32'h6004 + 32'(8 * k), 1'b0, 32'h0));
      step(1'b0, 1'b0);
    end
    bundle(2'b11, mk(32'h7000, 1'b0, 32'h0), mk(32'h7004, 1'b0, 32'h0));
    step(1'b1, 1'b1);
    idle();
    chk("t5_valid", 128'(out_valid), 128'd0);
    chk("t5_count", 128'(dut.count), 128'd0);
    chk("t5_stall", 128'(fetch_stall), 128'd0);
    step(1'b0, 1'b0);

    // Lone slot-1 instruction compacts into slot 0
    bundle(2'b10, mk(32'h500, 1'b0, 32'h0), mk(32'h504, 1'b1, 32'h800));
    step(1'b0, 1'b0);
    idle();
    chk("t6_valid", 128'(out_valid), 128'd1);
    chk("t6_addr0", 128'(out_inst_addr_0), 128'h504);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Asynchronous reset mid-operation drops everything immediately
    bundle(2'b11, mk(32'h9000, 1'b0, 32'h0), mk(32'h9004, 1'b0, 32'h0));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("t7_valid", 128'(out_valid), 128'd0);
    chk("t7_count", 128'(dut.count), 128'd0);
    chk("t7_stall", 128'(fetch_stall), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
